// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage register with an optional 2-entry skid buffer.
// Synchronous flush inserts a bubble and drops held beats as well as any beat arriving in the same cycle.
module pipe_stage_skid #(
  parameter int unsigned        DATA_W  = 64,
  parameter bit                 SKID    = 1'b1,
  parameter logic [DATA_W-1:0]  NOP_VAL = '0
) (
  input  logic              clk_PIPE,
  input  logic              rst_n_PIPE,
  input  logic              in_valid_PIPE,
  output logic              in_ready_PIPE,
  input  logic [DATA_W-1:0] in_data_PIPE,
  input  logic              flush_PIPE,
  output logic              out_valid_PIPE,
  input  logic              out_ready_PIPE,
  output logic [DATA_W-1:0] out_data_PIPE,
  output logic [1:0]        occ_PIPE
);

  // The encoding equals the number of held beats, so occ is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_q, ready_d;
  logic              alive_q;
  logic              acc, drn;

  assign out_valid_PIPE = (state_q != ST_EMPTY);
  assign out_data_PIPE  = main_q;
  assign occ_PIPE       = state_q;

  // Without the skid, ready must see out_ready directly to keep full throughput.
  assign in_ready_PIPE  = SKID ? ready_q
                               : (alive_q & (~out_valid_PIPE | out_ready_PIPE));

  assign acc = in_valid_PIPE & in_ready_PIPE;
  assign drn = out_valid_PIPE & out_ready_PIPE;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_PIPE) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_FULL;
            main_d  = in_data_PIPE;
          end
        end
        ST_FULL: begin
          if (acc && drn) begin
            main_d = in_data_PIPE;
          end else if (acc && SKID) begin
            state_d = ST_SKID;
            skid_d  = in_data_PIPE;
          end else if (drn) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VAL;
          end
        end
        ST_SKID: begin
          if (drn) begin
            state_d = ST_FULL;
            main_d  = skid_q;
            skid_d  = NOP_VAL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end
    ready_d = (state_d != ST_SKID);
  end

  always_ff @(posedge clk_PIPE or negedge rst_n_PIPE) begin
    if (!rst_n_PIPE) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
      ready_q <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      alive_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance on a shared clock and reset.
module tb_pipe_stage_skid;

  localparam int unsigned       DW  = 16;
  localparam logic [DW-1:0]     NOP = 16'h0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occ;
  logic          b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occ;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_skid #(.DATA_W(DW), .SKID(1'b1), .NOP_VAL(NOP)) u_a (
    .clk_PIPE(clk), .rst_n_PIPE(rst_n),
    .in_valid_PIPE(a_in_valid), .in_ready_PIPE(a_in_ready), .in_data_PIPE(a_in_data),
    .flush_PIPE(a_flush),
    .out_valid_PIPE(a_out_valid), .out_ready_PIPE(a_out_ready), .out_data_PIPE(a_out_data),
    .occ_PIPE(a_occ)
  );

  pipe_stage_skid #(.DATA_W(DW), .SKID(1'b0), .NOP_VAL(NOP)) u_b (
    .clk_PIPE(clk), .rst_n_PIPE(rst_n),
    .in_valid_PIPE(b_in_valid), .in_ready_PIPE(b_in_ready), .in_data_PIPE(b_in_data),
    .flush_PIPE(b_flush),
    .out_valid_PIPE(b_out_valid), .out_ready_PIPE(b_out_ready), .out_data_PIPE(b_out_data),
    .occ_PIPE(b_occ)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [DW-1:0] d,
                       input logic [1:0] o, input logic r);
    chk({tag, ".valid"}, 32'(a_out_valid), 32'(v));
    chk({tag, ".data"},  32'(a_out_data),  32'(d));
    chk({tag, ".occ"},   32'(a_occ),       32'(o));
    chk({tag, ".ready"}, 32'(a_in_ready),  32'(r));
  endtask

  logic          m_full;
  logic [DW-1:0] m_data, nxt;
  logic          m_acc, m_rdy;
  logic [7:0]    pat;

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'h1234; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_data = 16'h1234; b_flush = 1'b0; b_out_ready = 1'b1;

    // 1: reset with a beat presented
    tick(); tick();
    chk("rst.a.valid", 32'(a_out_valid), 32'd0);
    chk("rst.a.data",  32'(a_out_data),  32'(NOP));
    chk("rst.a.occ",   32'(a_occ),       32'd0);
    chk("rst.b.valid", 32'(b_out_valid), 32'd0);
    chk("rst.b.data",  32'(b_out_data),  32'(NOP));
    chk("rst.b.occ",   32'(b_occ),       32'd0);
    rst_n = 1'b1; a_in_valid = 1'b0; b_in_valid = 1'b0;
    tick();
    chk("rst.a.ready_after", 32'(a_in_ready), 32'd1);
    chk("rst.b.ready_after", 32'(b_in_ready), 32'd1);
    chk("rst.a.no_accept",   32'(a_occ),      32'd0);

    // 2: streaming, one beat per cycle
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1; a_in_data = 16'(16'hA0 + i);
      tick();
      chk_a($sformatf("stream%0d", i), 1'b1, 16'(16'hA0 + i), 2'd1, 1'b1);
    end
    a_in_valid = 1'b0;
    tick();
    chk_a("stream.drain", 1'b0, NOP, 2'd0, 1'b1);

    // 3: backpressure fills main and skid
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'hB0;
    tick(); chk_a("bp.b0", 1'b1, 16'hB0, 2'd1, 1'b1);
    a_in_data = 16'hB1;
    tick(); chk_a("bp.b1", 1'b1, 16'hB0, 2'd2, 1'b0);
    a_in_data = 16'hB2;
    tick(); chk_a("bp.hold", 1'b1, 16'hB0, 2'd2, 1'b0);
    a_out_ready = 1'b1;
    tick(); chk_a("bp.rel1", 1'b1, 16'hB1, 2'd1, 1'b1);
    tick(); chk_a("bp.rel2", 1'b1, 16'hB2, 2'd1, 1'b1);
    a_in_valid = 1'b0;
    tick(); chk_a("bp.empty", 1'b0, NOP, 2'd0, 1'b1);

    // 4: flush in SKID state with a beat offered, then flush in FULL with a real handshake
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'hC3;
    tick(); a_in_data = 16'hC4;
    tick(); chk_a("fl.pre", 1'b1, 16'hC3, 2'd2, 1'b0);
    a_flush = 1'b1; a_in_data = 16'hC5;
    tick(); a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    chk_a("fl.skid", 1'b0, NOP, 2'd0, 1'b1);
    tick(); chk_a("fl.no_c5", 1'b0, NOP, 2'd0, 1'b1);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'hD0;
    tick(); chk_a("fl.d0", 1'b1, 16'hD0, 2'd1, 1'b1);
    a_flush = 1'b1; a_in_data = 16'hD1;
    tick(); a_flush = 1'b0; a_in_valid = 1'b0;
    chk_a("fl.full", 1'b0, NOP, 2'd0, 1'b1);

    // 5: SKID=0 instance, in_ready is combinational on out_ready
    b_in_valid = 1'b1; b_in_data = 16'hE0; b_out_ready = 1'b0;
    tick();
    chk("b.fill.data", 32'(b_out_data), 32'hE0);
    chk("b.fill.occ",  32'(b_occ),      32'd1);
    chk("b.ready_lo",  32'(b_in_ready), 32'd0);
    b_out_ready = 1'b1; #1;
    chk("b.ready_comb_hi", 32'(b_in_ready), 32'd1);
    b_out_ready = 1'b0; #1;
    chk("b.ready_comb_lo", 32'(b_in_ready), 32'd0);
    m_full = 1'b1; m_data = 16'hE0; nxt = 16'hE1;
    pat = 8'b1011_0101;
    for (int i = 0; i < 8; i++) begin
      b_out_ready = pat[i]; b_in_data = nxt; #1;
      m_rdy = ~m_full | b_out_ready;
      chk($sformatf("b.alt%0d.ready", i), 32'(b_in_ready), 32'(m_rdy));
      m_acc = b_in_valid & m_rdy;
      if (m_acc) begin
        m_data = nxt; m_full = 1'b1; nxt = nxt + 16'd1;
      end else if (m_full && b_out_ready) begin
        m_full = 1'b0;
      end
      tick();
      chk($sformatf("b.alt%0d.valid", i), 32'(b_out_valid), 32'(m_full));
      chk($sformatf("b.alt%0d.data", i),  32'(b_out_data),  32'(m_full ? m_data : NOP));
      chk($sformatf("b.alt%0d.occ", i),   32'(b_occ),       32'(m_full));
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    tick();
    chk("b.drain", 32'(b_out_valid), 32'd0);

    // 6: async reset between edges while two beats are held
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'hF0;
    tick(); a_in_data = 16'hF1;
    tick(); a_in_valid = 1'b0;
    chk_a("ar.pre", 1'b1, 16'hF0, 2'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid", 32'(a_out_valid), 32'd0);
    chk("ar.data",  32'(a_out_data),  32'(NOP));
    chk("ar.occ",   32'(a_occ),       32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk_a("ar.after", 1'b0, NOP, 2'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
